div_ctrl: RTL and testbench

Multi-cycle divide sequencer for the EX stage. It accepts a DIV/DIVU request from EX and runs a 32-iteration restoring division. It returns a 64-bit {remainder, quotient} result that EX forwards down the pipe as the HI/LO write values. While the divide is busy it raises a stall request so the pipeline controller freezes the stages from IF through EX.

---
 rtl/div_ctrl.sv | 119 +++++++++++
 tb/tb_div_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// Multi-cycle restoring divide sequencer for EX: DIV/DIVU with
// {remainder, quotient} result and a pipeline stall request.
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t      state, state_n;
    logic [5:0]  cnt, cnt_n;
    logic [63:0] pair, pair_n;
    logic [31:0] dvs, dvs_n;
    logic        neg_q, neg_q_n;
    logic        neg_r, neg_r_n;
    logic [63:0] result_n;
    logic        ready_n;

    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic        ge;
    logic [63:0] step;
    logic [31:0] quot;
    logic [31:0] rem;

    // Shifted partial remainder is 33 bits wide; a set top bit always fits.
    assign rem_sh = pair[63:31];
    assign diff   = rem_sh - {1'b0, dvs};
    assign ge     = rem_sh[32] | ~diff[32];
    assign step   = {ge ? diff[31:0] : rem_sh[31:0], pair[30:0], ge};
    assign quot   = neg_q ? 32'd0 - step[31:0] : step[31:0];
    assign rem    = neg_r ? 32'd0 - step[63:32] : step[63:32];

    assign stallreq_o = start_i & ~ready_o & ~annul_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= '0;
            pair     <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pair     <= pair_n;
            dvs      <= dvs_n;
            neg_q    <= neg_q_n;
            neg_r    <= neg_r_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        pair_n   = pair;
        dvs_n    = dvs;
        neg_q_n  = neg_q;
        neg_r_n  = neg_r;
        result_n = result_o;
        ready_n  = ready_o;
        if (annul_i) begin
            state_n  = FREE;
            result_n = '0;
            ready_n  = 1'b0;
        end else begin
            case (state)
                FREE: begin
                    if (start_i) begin
                        neg_r_n = signed_div_i & opdata1_i[31];
                        neg_q_n = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        dvs_n   = (signed_div_i & opdata2_i[31])
                                  ? 32'd0 - opdata2_i : opdata2_i;
                        pair_n  = {32'd0, (signed_div_i & opdata1_i[31])
                                  ? 32'd0 - opdata1_i : opdata1_i};
                        cnt_n   = '0;
                        state_n = (opdata2_i == 32'd0) ? BYZERO : ON;
                    end
                end
                BYZERO: begin
                    state_n  = END;
                    result_n = '0;
                    ready_n  = 1'b1;
                end
                ON: begin
                    pair_n = step;
                    cnt_n  = cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state_n  = END;
                        result_n = {rem, quot};
                        ready_n  = 1'b1;
                    end
                end
                END: begin
                    if (!start_i) begin
                        state_n  = FREE;
                        result_n = '0;
                        ready_n  = 1'b0;
                    end
                end
                default: state_n = FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: directed corner cases plus random divides
// compared against a plain-arithmetic reference.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int errors = 0;
    int checks = 0;

    div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic sgn,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint la, lb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
        end else begin
            la = longint'({32'd0, a});
            lb = longint'({32'd0, b});
        end
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    // Starts a divide at a negedge, expects completion, holds, releases.
    task automatic do_div(input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        logic [63:0] exp;
        int n;
        int exp_n;
        logic got;
        exp   = model(sgn, a, b);
        exp_n = (b == 32'd0) ? 2 : 33;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        #1;
        chk("stall_req", {63'd0, stallreq_o}, 64'd1);
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = $urandom_range(0, 1);
            end
            if (ready_o) got = 1'b1;
            else chk("stall_busy", {63'd0, stallreq_o}, 64'd1);
        end
        chk("latency", 64'(n), 64'(exp_n));
        chk("result", result_o, exp);
        chk("stall_done", {63'd0, stallreq_o}, 64'd0);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_result", result_o, exp);
            chk("hold_ready", {63'd0, ready_o}, 64'd1);
        end
        start_i = 1'b0;
        @(negedge clk);
        chk("drop_ready", {63'd0, ready_o}, 64'd0);
        chk("drop_result", result_o, 64'd0);
    endtask

    // Starts a divide and kills it mid-ON with annul or reset.
    task automatic kill_div(input logic use_rst, input int cyc);
        signed_div_i = 1'b0;
        opdata1_i    = $urandom;
        opdata2_i    = $urandom_range(1, 1000);
        start_i      = 1'b1;
        repeat (cyc + 1) @(negedge clk);
        chk("kill_busy", {63'd0, ready_o}, 64'd0);
        if (use_rst) rst = 1'b1;
        else annul_i = 1'b1;
        #1;
        if (!use_rst) chk("annul_stall", {63'd0, stallreq_o}, 64'd0);
        @(negedge clk);
        chk("kill_ready", {63'd0, ready_o}, 64'd0);
        chk("kill_result", result_o, 64'd0);
        rst     = 1'b0;
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        chk("kill_idle", {63'd0, ready_o}, 64'd0);
    endtask

    initial begin
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {63'd0, ready_o}, 64'd0);
        chk("rst_result", result_o, 64'd0);
        chk("rst_stall", {63'd0, stallreq_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        do_div(1'b0, 32'd100, 32'd7, 0);
        do_div(1'b1, 32'hFFFFFFF9, 32'h00000002, 1);
        do_div(1'b1, 32'h00000007, 32'hFFFFFFFE, 0);
        do_div(1'b0, 32'd5, 32'd0, 0);
        do_div(1'b1, 32'hFFFFFFF0, 32'd0, 2);
        kill_div(1'b0, 10);
        do_div(1'b0, 32'hFFFFFFFF, 32'h10, 0);
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
        kill_div(1'b1, 15);
        do_div(1'b0, 32'hDEADBEEF, 32'h1234, 5);
        do_div(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        do_div(1'b0, 32'h12345678, 32'hFFFFFFFF, 0);
        do_div(1'b1, 32'h7FFFFFFF, 32'h80000000, 0);

        for (int i = 0; i < 20; i++) begin
            logic        s;
            logic [31:0] a;
            logic [31:0] b;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = $urandom_range(1, 300);
                2: b = 32'hFFFFFFFF - $urandom_range(0, 50);
                default: b = $urandom;
            endcase
            do_div(s, a, b, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
